// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx
// Serialises a 4-bit pattern MSB first and repeats it rep+1 times. GAP_LEN
// idle bit-times separate consecutive repetitions. One FIN cycle with a done
// pulse closes the transmission.
//
// Parameters
//   GAP_LEN     : idle bit-times between repetitions (0..15)
// Ports
//   clk         : clock; all state changes on the rising edge
//   rst         : synchronous active-high reset
//   pat[3:0]    : pattern to send, captured on accept
//   rep[3:0]    : repetitions minus one, captured on accept
//   start_valid : transmission request
//   abort       : cancels the transmission in progress
//   start_ready : high in IDLE, when a request can be accepted
//   x           : serial data bit
//   x_valid     : x carries a pattern bit this cycle
//   busy        : high whenever not IDLE
//   done        : one-cycle pulse in the FIN cycle
module seq_pattern_tx #(
  parameter int GAP_LEN = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] pat,
  input  logic [3:0] rep,
  input  logic       start_valid,
  input  logic       abort,
  output logic       start_ready,
  output logic       x,
  output logic       x_valid,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;
  localparam logic [1:0] FIN  = 2'd3;

  localparam logic       HAS_GAP  = (GAP_LEN != 0);
  // Gap counter is loaded with GAP_LEN-1 and leaves GAP after reaching 0.
  localparam logic [3:0] GAP_LAST = (GAP_LEN == 0) ? 4'd0 : 4'(GAP_LEN - 1);

  logic [1:0] state_reg, state_next;
  logic [1:0] idx_reg, idx_next;
  logic [3:0] rep_cnt_reg, rep_cnt_next;
  logic [3:0] pat_reg, pat_next;
  logic [3:0] gap_cnt_reg, gap_cnt_next;
  logic       x_reg, x_next;
  logic       x_valid_reg, x_valid_next;
  logic       done_reg, done_next;
  logic       busy_reg, busy_next;

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    rep_cnt_next = rep_cnt_reg;
    pat_next     = pat_reg;
    gap_cnt_next = gap_cnt_reg;

    case (state_reg)
      IDLE: begin
        if (start_valid) begin
          state_next   = SEND;
          idx_next     = 2'd3;
          pat_next     = pat;
          rep_cnt_next = rep;
        end
      end
      SEND: begin
        if (idx_reg != 2'd0) begin
          idx_next = idx_reg - 2'd1;
        end else if (rep_cnt_reg == 4'd0) begin
          state_next = FIN;
        end else begin
          rep_cnt_next = rep_cnt_reg - 4'd1;
          idx_next     = 2'd3;
          // Without a gap the next repetition follows with no bubble.
          if (HAS_GAP) begin
            state_next   = GAP;
            gap_cnt_next = GAP_LAST;
          end
        end
      end
      GAP: begin
        if (gap_cnt_reg == 4'd0) begin
          state_next = SEND;
        end else begin
          gap_cnt_next = gap_cnt_reg - 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Abort only matters outside IDLE; in IDLE a simultaneous request wins.
    if (abort && (state_reg != IDLE)) begin
      state_next = IDLE;
    end

    // Outputs are registered versions of what the next state implies, so they
    // line up with the state they describe.
    x_valid_next = (state_next == SEND);
    x_next       = (state_next == SEND) & pat_next[idx_next];
    done_next    = (state_next == FIN);
    busy_next    = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      idx_reg     <= 2'd0;
      rep_cnt_reg <= 4'd0;
      pat_reg     <= 4'd0;
      gap_cnt_reg <= 4'd0;
      x_reg       <= 1'b0;
      x_valid_reg <= 1'b0;
      done_reg    <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      rep_cnt_reg <= rep_cnt_next;
      pat_reg     <= pat_next;
      gap_cnt_reg <= gap_cnt_next;
      x_reg       <= x_next;
      x_valid_reg <= x_valid_next;
      done_reg    <= done_next;
      busy_reg    <= busy_next;
    end
  end

  assign start_ready = (state_reg == IDLE);
  assign x           = x_reg;
  assign x_valid     = x_valid_reg;
  assign done        = done_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx
// Drives two instances in parallel (GAP_LEN=2 and GAP_LEN=0) with shared
// inputs. The reference model gives the expected outputs for each cycle
// after accept, using only the stream-length arithmetic.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] pat_in = 4'd0;
  logic [3:0] rep_in = 4'd0;
  logic       start_valid = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] start_ready_o, x_o, x_valid_o, busy_o, done_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_pattern_tx #(.GAP_LEN(2)) u_gap2 (
    .clk(clk), .rst(rst), .pat(pat_in), .rep(rep_in),
    .start_valid(start_valid), .abort(abort),
    .start_ready(start_ready_o[0]), .x(x_o[0]), .x_valid(x_valid_o[0]),
    .busy(busy_o[0]), .done(done_o[0])
  );

  seq_pattern_tx #(.GAP_LEN(0)) u_gap0 (
    .clk(clk), .rst(rst), .pat(pat_in), .rep(rep_in),
    .start_valid(start_valid), .abort(abort),
    .start_ready(start_ready_o[1]), .x(x_o[1]), .x_valid(x_valid_o[1]),
    .busy(busy_o[1]), .done(done_o[1])
  );

  function automatic int gap_of(int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic int span(int g, int rep);
    return 4 * (rep + 1) + g * rep;
  endfunction

  // Expected {x_valid, x, done, busy} at position p (p=0 is the cycle after accept).
  function automatic logic [3:0] model(int g, logic [3:0] pat, int rep, int p);
    int t;
    int o;
    t = span(g, rep);
    if (p < t) begin
      o = p % (4 + g);
      if (o < 4) return {1'b1, pat[3 - o], 1'b0, 1'b1};
      return 4'b0001;
    end
    if (p == t) return 4'b0011;
    return 4'b0000;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy_o != 2'b00 || start_ready_o != 2'b11) && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 400) begin
      failures++;
      $display("FAIL wait_idle busy=%b start_ready=%b required busy=00 start_ready=11", busy_o, start_ready_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_valid = 1'b1;
    abort = 1'b1;
    pat_in = 4'b1111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({x_valid_o[i], x_o[i], done_o[i], busy_o[i], start_ready_o[i]} !== 5'b00001) begin
        failures++;
        $display("FAIL reset inst=%0d got xv,x,done,busy,rdy=%b required 00001", i,
                 {x_valid_o[i], x_o[i], done_o[i], busy_o[i], start_ready_o[i]});
      end
    end
    rst = 1'b0;
    start_valid = 1'b0;
    abort = 1'b0;
    $display("reset: outputs checked");
  endtask

  // One transmission; with hold, start_valid stays high throughout so only
  // the cycles up to the first IDLE cycle are checked.
  task automatic run_stream(input logic [3:0] pat, input int rep, input bit hold);
    int len;
    int nvalid[2];
    int ndone[2];
    logic [3:0] e;
    @(negedge clk);
    pat_in = pat;
    rep_in = 4'(rep);
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start_valid = 1'b0;
    pat_in = 4'($urandom);
    rep_in = 4'($urandom);
    len = span(2, rep) + 3;
    nvalid[0] = 0; nvalid[1] = 0; ndone[0] = 0; ndone[1] = 0;
    for (int p = 0; p < len; p++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!hold || p <= span(gap_of(i), rep) + 1) begin
          e = model(gap_of(i), pat, rep, p);
          nvalid[i] += int'(x_valid_o[i]);
          ndone[i]  += int'(done_o[i]);
          checks++;
          if ({x_valid_o[i], x_o[i], done_o[i], busy_o[i]} !== e) begin
            failures++;
            $display("FAIL stream gap=%0d pat=%b rep=%0d p=%0d got xv,x,done,busy=%b required %b",
                     gap_of(i), pat, rep, p, {x_valid_o[i], x_o[i], done_o[i], busy_o[i]}, e);
          end
          checks++;
          if (start_ready_o[i] !== ~e[0]) begin
            failures++;
            $display("FAIL start_ready gap=%0d p=%0d got %b required %b", gap_of(i), p, start_ready_o[i], ~e[0]);
          end
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (nvalid[i] != 4 * (rep + 1) || ndone[i] != 1) begin
        failures++;
        $display("FAIL counts gap=%0d rep=%0d got valid=%0d done=%0d required valid=%0d done=1",
                 gap_of(i), rep, nvalid[i], ndone[i], 4 * (rep + 1));
      end
    end
    start_valid = 1'b0;
    wait_idle();
    $display("stream: pat=%b rep=%0d hold=%0d", pat, rep, hold);
  endtask

  task automatic test_directed();
    run_stream(4'b1010, 0, 1'b0);
    run_stream(4'b1100, 2, 1'b0);
    run_stream(4'b0110, 1, 1'b0);
    run_stream(4'b1111, 15, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) run_stream(4'($urandom), int'($urandom_range(0, 5)), 1'b0);
  endtask

  task automatic test_start_ignored();
    run_stream(4'($urandom), 2, 1'b1);
  endtask

  task automatic test_abort(input int ap);
    logic [3:0] pat;
    logic [3:0] npat;
    logic [3:0] e;
    pat = 4'($urandom);
    npat = 4'($urandom);
    @(negedge clk);
    pat_in = pat;
    rep_in = 4'd2;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    for (int p = 0; p <= ap; p++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        e = model(gap_of(i), pat, 2, p);
        checks++;
        if ({x_valid_o[i], x_o[i], done_o[i], busy_o[i]} !== e) begin
          failures++;
          $display("FAIL abort_pre gap=%0d p=%0d got %b required %b", gap_of(i), p,
                   {x_valid_o[i], x_o[i], done_o[i], busy_o[i]}, e);
        end
      end
    end
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({x_valid_o[i], x_o[i], done_o[i], busy_o[i], start_ready_o[i]} !== 5'b00001) begin
        failures++;
        $display("FAIL abort_idle gap=%0d got xv,x,done,busy,rdy=%b required 00001", gap_of(i),
                 {x_valid_o[i], x_o[i], done_o[i], busy_o[i], start_ready_o[i]});
      end
    end
    pat_in = npat;
    rep_in = 4'd0;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({x_valid_o[i], x_o[i], done_o[i], busy_o[i]} !== {1'b1, npat[3], 2'b01}) begin
        failures++;
        $display("FAIL abort_restart gap=%0d got %b required %b", gap_of(i),
                 {x_valid_o[i], x_o[i], done_o[i], busy_o[i]}, {1'b1, npat[3], 2'b01});
      end
    end
    wait_idle();
    $display("abort: at p=%0d pat=%b new=%b", ap, pat, npat);
  endtask

  task automatic test_abort_idle();
    logic [3:0] pat;
    pat = 4'($urandom);
    @(negedge clk);
    pat_in = pat;
    rep_in = 4'd0;
    abort = 1'b1;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    start_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({x_valid_o[i], x_o[i], busy_o[i], start_ready_o[i]} !== {1'b1, pat[3], 2'b10}) begin
        failures++;
        $display("FAIL abort_in_idle gap=%0d got xv,x,busy,rdy=%b required %b", gap_of(i),
                 {x_valid_o[i], x_o[i], busy_o[i], start_ready_o[i]}, {1'b1, pat[3], 2'b10});
      end
    end
    wait_idle();
    $display("abort_idle: pat=%b", pat);
  endtask

  task automatic test_rst_gap();
    logic [3:0] pat;
    logic [3:0] e;
    pat = 4'($urandom);
    @(negedge clk);
    pat_in = pat;
    rep_in = 4'd2;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    // p=4 is a GAP cycle for the GAP_LEN=2 instance.
    for (int p = 0; p <= 4; p++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        e = model(gap_of(i), pat, 2, p);
        checks++;
        if ({x_valid_o[i], x_o[i], done_o[i], busy_o[i]} !== e) begin
          failures++;
          $display("FAIL rst_pre gap=%0d p=%0d got %b required %b", gap_of(i), p,
                   {x_valid_o[i], x_o[i], done_o[i], busy_o[i]}, e);
        end
      end
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({x_valid_o[i], x_o[i], done_o[i], busy_o[i], start_ready_o[i]} !== 5'b00001) begin
        failures++;
        $display("FAIL rst_mid gap=%0d got xv,x,done,busy,rdy=%b required 00001", gap_of(i),
                 {x_valid_o[i], x_o[i], done_o[i], busy_o[i], start_ready_o[i]});
      end
    end
    start_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({done_o[i], busy_o[i]} !== 2'b00) begin
        failures++;
        $display("FAIL rst_residual gap=%0d got done,busy=%b required 00", gap_of(i), {done_o[i], busy_o[i]});
      end
    end
    wait_idle();
    $display("rst_gap: pat=%b", pat);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_abort(7);
    test_abort(4);
    test_abort_idle();
    test_rst_gap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
